trap_ctrl: RTL and testbench
============================

# trap_ctrl

Parametrised machine-mode trap controller for the RV32 core. It accepts decode and execute exceptions, the standard timer, software and external interrupts, and `NUM_PLAT_IRQ` platform interrupt lines. It sequences the CSR updates (mepc, mstatus, mcause, mtval) over the single CSR write port and redirects fetch to `mtvec`, which supports direct and vectored modes. It also handles `mret`. It sits between decoder/exe, the CSR regfile and top control, and replaces the fixed 8-source controller.

## Interface
- `NUM_PLAT_IRQ`, default 4: platform interrupt lines (legal range 1..16). Line i maps to cause 16+i and enable bit `mie[16+i]`.
- `VECTORED_EN`, default 1: 1 allows vectored mode (`mtvec[1:0]==2'b01`); 0 always uses direct mode.
- `clk` in 1: clock.
- `rst_b` in 1: reset, asynchronous, active-low.
- `ecall_dec`, `ebreak_dec`, `mret_dec`, `illegal_inst_dec` in 1 each: decode-stage events.
- `pc_dec` in 32: PC of the decode instruction.
- `inst_dec` in 32: encoding of the decode instruction.
- `load_addr_mis_exe`, `store_addr_mis_exe` in 1 each: misaligned memory access flags.
- `mem_addr_exe` in 32: faulting memory address.
- `irq_ext`, `irq_soft`, `irq_timer` in 1 each: level-sensitive standard interrupts.
- `irq_plat` in `NUM_PLAT_IRQ`: level-sensitive platform interrupts.
- `mstatus_csr`, `mie_csr`, `mtvec_csr`, `mepc_csr` in 32 each: current CSR values.
- `csr_wen` out 1, `csr_waddr` out 12, `csr_wdata` out 32: CSR write port.
- `mip_out` out 32: live pending view for the CSR regfile. Bit 11 = `irq_ext`, bit 3 = `irq_soft`, bit 7 = `irq_timer`, bit 16+i = `irq_plat[i]`, all others 0.
- `pipe_flush` out 1: kill younger instructions in the pipeline.
- `busy` out 1: controller is not IDLE.
- `jump_valid` out 1: one-cycle fetch redirect.
- `jump_addr` out 32: redirect target.
- `irq_ack` out `NUM_PLAT_IRQ`+3: one-hot acknowledge `{plat, timer, soft, ext}`, pulsed in JUMP for a taken interrupt.

## Operation
- **Interrupt eligibility.** An interrupt is eligible when its pending bit is set, its `mie_csr` bit is set, and `mstatus_csr[3]` (MIE) is 1.
- **Exception detection.** Instruction address misaligned is `|pc_dec[1:0]`.
- **Priority** (highest first, exceptions before interrupts):
  - inst-misaligned (cause 0), illegal (2), ebreak (3), ecall (11), load-misaligned (4), store-misaligned (6);
  - then ext (0x8000000B), soft (0x80000003), timer (0x80000007), `plat[0]`…`plat[N-1]` (0x80000010+i).
- **Accept.** A trap is accepted only in IDLE. On acceptance the controller captures cause, mepc, mtval and the interrupt flag. It then runs IDLE→EPC→STATUS→CAUSE→TVAL→JUMP→IDLE.
- **Captured values.**
  - mepc = `pc_dec`.
  - mtval: `inst_dec` for illegal, `pc_dec` for inst-misaligned and ebreak, `mem_addr_exe` for load/store misaligned, 0 otherwise.
- **Writes per state** (one per state, from captured registers):
  - EPC: 0x341 ← mepc.
  - STATUS: 0x300 ← `mstatus_csr` with MPIE[7] ← MIE[3], MIE ← 0, MPP[12:11] ← 2'b11.
  - CAUSE: 0x342.
  - TVAL: 0x343.
- **Jump target.**
  - If `VECTORED_EN` is 1, `mtvec[1:0]==01` and the trap is an interrupt: `{mtvec[31:2],2'b00} + 4*cause[4:0]`.
  - Otherwise: `{mtvec[31:2],2'b00}`.
- **mret.** `mret_dec` in IDLE with no trap runs IDLE→RSTATUS→RJUMP→IDLE.
  - RSTATUS: 0x300 ← MIE ← MPIE, MPIE ← 1, MPP ← 2'b11; all other bits unchanged.
  - RJUMP: `jump_addr = mepc_csr`.
- **Boundary conditions.**
  - Trap and `mret_dec` in the same IDLE cycle: the trap wins and the mret is flushed.
  - Events arriving while `busy`: ignored. Level interrupts are re-evaluated on return to IDLE.
  - Interrupt deasserted after acceptance: the sequence still completes with the captured cause.
  - Several sources in one cycle: only the highest priority is taken.

## Timing
- **Reset.** All outputs are 0, `mip_out` follows its inputs, and the state is IDLE. Reset mid-sequence aborts to IDLE with no further writes.
- **Trap sequence.** With acceptance in cycle T:
  - `pipe_flush` is combinational in T and held through JUMP (T+5);
  - `busy` is high T+1..T+5;
  - CSR writes occur T+1 (mepc), T+2 (mstatus), T+3 (mcause), T+4 (mtval);
  - `jump_valid` and `irq_ack` pulse in T+5;
  - the earliest next acceptance is T+6.
- **mret sequence.** With acceptance in T: flush in T..T+2, mstatus write in T+1, jump in T+2.
- All CSR write outputs are Moore outputs, decoded from the state register and captured data. `csr_wen` is 0 in IDLE, JUMP and RJUMP.

## Structure
- **Package `trap_pkg`:**
  - state enum (IDLE, EPC, STATUS, CAUSE, TVAL, JUMP, RSTATUS, RJUMP);
  - CSR address constants 0x300/0x341/0x342/0x343;
  - exception cause constants and interrupt cause base values.
- **Sub-module `trap_prio_enc`:** combinational. Inputs are the exception flags and the masked interrupt vector; outputs are `valid`, `is_irq`, `cause[31:0]` and the one-hot ack vector.

## Test plan
- **Illegal instruction.** `illegal_inst_dec`=1, `pc_dec`=0x100, `inst_dec`=0xFFFFFFFF → writes 0x341=0x100, 0x300 (MIE cleared, MPIE set), 0x342=2, 0x343=0xFFFFFFFF; jump to 0x80 with `mtvec`=0x80.
- **Vectored timer.** `mtvec`=0x201, MIE=1, `mie[7]`=1, `irq_timer`=1 → mcause 0x80000007, mtval 0; jump to 0x21C.
- **Platform interrupt.** `NUM_PLAT_IRQ`=4, `irq_plat[2]` enabled → mcause 0x80000012; `irq_ack`=7'b0100000 pulse in T+5.
- **Simultaneous events.** ecall + `irq_ext` + `mret_dec` in one cycle → mcause 11, no ack pulse, mret dropped.
- **mret.** mstatus=0x1880 (MPIE=1, MIE=0), `mepc_csr`=0x104 → T+1 write 0x300=0x1888; T+2 jump to 0x104.
- **Reset mid-trap.** Assert `rst_b`=0 in the CAUSE state → `csr_wen`=0 and `busy`=0 immediately; no mtval write after release.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller:
// sequencer states, CSR addresses, cause codes and mstatus update helpers.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EPC,
        STATUS,
        CAUSE,
        TVAL,
        JUMP,
        RSTATUS,
        RJUMP
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_INST_MIS  = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MIS  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MIS = 32'd6;
    localparam logic [31:0] CAUSE_ECALL     = 32'd11;

    localparam logic [31:0] IRQ_CAUSE_EXT       = 32'h8000_000B;
    localparam logic [31:0] IRQ_CAUSE_SOFT      = 32'h8000_0003;
    localparam logic [31:0] IRQ_CAUSE_TIMER     = 32'h8000_0007;
    localparam logic [31:0] IRQ_CAUSE_PLAT_BASE = 32'h8000_0010;

    // idx follows the ack vector order {plat, timer, soft, ext}
    function automatic logic [31:0] irq_cause(input int unsigned idx);
        case (idx)
            0:       return IRQ_CAUSE_EXT;
            1:       return IRQ_CAUSE_SOFT;
            2:       return IRQ_CAUSE_TIMER;
            default: return IRQ_CAUSE_PLAT_BASE + (idx - 3);
        endcase
    endfunction

    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR-side bundle of the trap controller: current CSR values in, single
// CSR write port out. master = trap controller, slave = CSR regfile.
interface trap_ctrl_if;

    logic [31:0] mstatus_csr;
    logic [31:0] mie_csr;
    logic [31:0] mtvec_csr;
    logic [31:0] mepc_csr;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;

    modport master (
        input  mstatus_csr, mie_csr, mtvec_csr, mepc_csr,
        output csr_wen, csr_waddr, csr_wdata
    );

    modport slave (
        output mstatus_csr, mie_csr, mtvec_csr, mepc_csr,
        input  csr_wen, csr_waddr, csr_wdata
    );

endinterface

// File: rtl/trap_prio_enc.sv
// Combinational trap priority encoder: exceptions first in fixed order,
// then masked interrupts with the lowest vector index winning.
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 7
) (
    input  logic               inst_mis,
    input  logic               illegal,
    input  logic               ebreak,
    input  logic               ecall,
    input  logic               load_mis,
    input  logic               store_mis,
    input  logic [NUM_IRQ-1:0] irq_vec,
    output logic               valid,
    output logic               is_irq,
    output logic [31:0]        cause,
    output logic [NUM_IRQ-1:0] ack
);

    always_comb begin
        valid  = 1'b1;
        is_irq = 1'b0;
        cause  = '0;
        ack    = '0;
        if (inst_mis)       cause = CAUSE_INST_MIS;
        else if (illegal)   cause = CAUSE_ILLEGAL;
        else if (ebreak)    cause = CAUSE_EBREAK;
        else if (ecall)     cause = CAUSE_ECALL;
        else if (load_mis)  cause = CAUSE_LOAD_MIS;
        else if (store_mis) cause = CAUSE_STORE_MIS;
        else begin
            valid = 1'b0;
            // descending scan: the last hit, i.e. the lowest index, wins
            for (int unsigned i = NUM_IRQ; i > 0; i--) begin
                if (irq_vec[i-1]) begin
                    valid    = 1'b1;
                    is_irq   = 1'b1;
                    cause    = irq_cause(i - 1);
                    ack      = '0;
                    ack[i-1] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: accepts exceptions/interrupts and mret in
// IDLE, sequences mepc/mstatus/mcause/mtval writes, then redirects fetch.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned NUM_PLAT_IRQ = 4,
    parameter bit          VECTORED_EN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    ecall_dec,
    input  logic                    ebreak_dec,
    input  logic                    mret_dec,
    input  logic                    illegal_inst_dec,
    input  logic [31:0]             pc_dec,
    input  logic [31:0]             inst_dec,
    input  logic                    load_addr_mis_exe,
    input  logic                    store_addr_mis_exe,
    input  logic [31:0]             mem_addr_exe,
    input  logic                    irq_ext,
    input  logic                    irq_soft,
    input  logic                    irq_timer,
    input  logic [NUM_PLAT_IRQ-1:0] irq_plat,
    trap_ctrl_if.master             csr,
    output logic [31:0]             mip_out,
    output logic                    pipe_flush,
    output logic                    busy,
    output logic                    jump_valid,
    output logic [31:0]             jump_addr,
    output logic [NUM_PLAT_IRQ+2:0] irq_ack
);

    localparam int unsigned IRQW = NUM_PLAT_IRQ + 3;

    trap_state_e     state_q, state_d;
    logic [31:0]     epc_q, epc_d;
    logic [31:0]     cause_q, cause_d;
    logic [31:0]     tval_q, tval_d;
    logic            irq_q, irq_d;
    logic [IRQW-1:0] ack_q, ack_d;

    logic [31:0]     mip, irq_elig_all;
    logic [IRQW-1:0] irq_vec, trap_ack;
    logic            unused_elig;
    logic            inst_mis, trap_valid, trap_is_irq;
    logic [31:0]     trap_cause, trap_tval, tvec_base, trap_target;
    logic            csr_wen;
    logic [11:0]     csr_waddr;
    logic [31:0]     csr_wdata;

    always_comb begin
        mip                     = '0;
        mip[11]                 = irq_ext;
        mip[3]                  = irq_soft;
        mip[7]                  = irq_timer;
        mip[16 +: NUM_PLAT_IRQ] = irq_plat;
    end

    assign mip_out      = mip;
    assign irq_elig_all = mip & csr.mie_csr & {32{csr.mstatus_csr[3]}};
    assign unused_elig  = ^irq_elig_all;
    assign irq_vec      = {irq_elig_all[16 +: NUM_PLAT_IRQ], irq_elig_all[7],
                           irq_elig_all[3], irq_elig_all[11]};
    assign inst_mis     = |pc_dec[1:0];

    trap_prio_enc #(.NUM_IRQ(IRQW)) u_prio (
        .inst_mis  (inst_mis),
        .illegal   (illegal_inst_dec),
        .ebreak    (ebreak_dec),
        .ecall     (ecall_dec),
        .load_mis  (load_addr_mis_exe),
        .store_mis (store_addr_mis_exe),
        .irq_vec   (irq_vec),
        .valid     (trap_valid),
        .is_irq    (trap_is_irq),
        .cause     (trap_cause),
        .ack       (trap_ack)
    );

    // interrupt causes carry bit 31 and so never match an exception code here
    always_comb begin
        case (trap_cause)
            CAUSE_ILLEGAL:                 trap_tval = inst_dec;
            CAUSE_INST_MIS, CAUSE_EBREAK:  trap_tval = pc_dec;
            CAUSE_LOAD_MIS, CAUSE_STORE_MIS: trap_tval = mem_addr_exe;
            default:                       trap_tval = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        irq_d   = irq_q;
        ack_d   = ack_q;
        case (state_q)
            IDLE: begin
                if (trap_valid) begin
                    state_d = EPC;
                    epc_d   = pc_dec;
                    cause_d = trap_cause;
                    tval_d  = trap_tval;
                    irq_d   = trap_is_irq;
                    ack_d   = trap_ack;
                end else if (mret_dec) begin
                    state_d = RSTATUS;
                end
            end
            EPC:     state_d = STATUS;
            STATUS:  state_d = CAUSE;
            CAUSE:   state_d = TVAL;
            TVAL:    state_d = JUMP;
            RSTATUS: state_d = RJUMP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            irq_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            irq_q   <= irq_d;
            ack_q   <= ack_d;
        end
    end

    assign tvec_base   = {csr.mtvec_csr[31:2], 2'b00};
    assign trap_target = (VECTORED_EN && csr.mtvec_csr[1:0] == 2'b01 && irq_q)
                       ? tvec_base + {25'd0, cause_q[4:0], 2'b00} : tvec_base;

    always_comb begin
        csr_wen    = 1'b0;
        csr_waddr  = '0;
        csr_wdata  = '0;
        jump_valid = 1'b0;
        jump_addr  = '0;
        irq_ack    = '0;
        case (state_q)
            EPC:     begin csr_wen = 1'b1; csr_waddr = CSR_MEPC;    csr_wdata = epc_q; end
            STATUS:  begin csr_wen = 1'b1; csr_waddr = CSR_MSTATUS; csr_wdata = mstatus_on_trap(csr.mstatus_csr); end
            CAUSE:   begin csr_wen = 1'b1; csr_waddr = CSR_MCAUSE;  csr_wdata = cause_q; end
            TVAL:    begin csr_wen = 1'b1; csr_waddr = CSR_MTVAL;   csr_wdata = tval_q; end
            JUMP:    begin jump_valid = 1'b1; jump_addr = trap_target; irq_ack = ack_q; end
            RSTATUS: begin csr_wen = 1'b1; csr_waddr = CSR_MSTATUS; csr_wdata = mstatus_on_mret(csr.mstatus_csr); end
            RJUMP:   begin jump_valid = 1'b1; jump_addr = csr.mepc_csr; end
            default: ;
        endcase
    end

    assign csr.csr_wen   = csr_wen;
    assign csr.csr_waddr = csr_waddr;
    assign csr.csr_wdata = csr_wdata;

    // flush covers the accepting IDLE cycle combinationally; held low in reset
    assign pipe_flush = (state_q != IDLE) || (rst_b && (trap_valid || mret_dec));
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl against a cause/priority reference model
// built from mip bit positions, plus directed scenarios and mid-trap reset.
module tb_trap_ctrl;

    localparam int unsigned N    = 4;
    localparam int unsigned IRQW = N + 3;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          ecall_dec, ebreak_dec, mret_dec, illegal_inst_dec;
    logic [31:0]   pc_dec, inst_dec, mem_addr_exe;
    logic          load_addr_mis_exe, store_addr_mis_exe;
    logic          irq_ext, irq_soft, irq_timer;
    logic [N-1:0]  irq_plat;
    logic [31:0]   mip_out, jump_addr;
    logic          pipe_flush, busy, jump_valid;
    logic [IRQW-1:0] irq_ack;

    trap_ctrl_if csr_bus();

    trap_ctrl #(.NUM_PLAT_IRQ(N), .VECTORED_EN(1'b1)) dut (
        .clk                (clk),
        .rst_b              (rst_b),
        .ecall_dec          (ecall_dec),
        .ebreak_dec         (ebreak_dec),
        .mret_dec           (mret_dec),
        .illegal_inst_dec   (illegal_inst_dec),
        .pc_dec             (pc_dec),
        .inst_dec           (inst_dec),
        .load_addr_mis_exe  (load_addr_mis_exe),
        .store_addr_mis_exe (store_addr_mis_exe),
        .mem_addr_exe       (mem_addr_exe),
        .irq_ext            (irq_ext),
        .irq_soft           (irq_soft),
        .irq_timer          (irq_timer),
        .irq_plat           (irq_plat),
        .csr                (csr_bus),
        .mip_out            (mip_out),
        .pipe_flush         (pipe_flush),
        .busy               (busy),
        .jump_valid         (jump_valid),
        .jump_addr          (jump_addr),
        .irq_ack            (irq_ack)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] obs_w [5];
    logic [31:0] obs_jump;
    logic [IRQW-1:0] obs_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mip();
        logic [31:0] m;
        m     = '0;
        m[11] = irq_ext;
        m[3]  = irq_soft;
        m[7]  = irq_timer;
        for (int unsigned i = 0; i < N; i++) m[16+i] = irq_plat[i];
        return m;
    endfunction

    // Interrupt cause equals its mip bit position with bit 31 set.
    task automatic ref_trap(output bit take, output bit irq, output logic [31:0] cause,
                            output logic [31:0] tval, output int ack_idx);
        bit          exc [6];
        int unsigned exc_cause [6];
        logic [31:0] mip, mie;
        int unsigned pos;
        mip       = ref_mip();
        mie       = csr_bus.mie_csr;
        exc       = '{pc_dec[1:0] != 2'b00, illegal_inst_dec, ebreak_dec, ecall_dec,
                      load_addr_mis_exe, store_addr_mis_exe};
        exc_cause = '{0, 2, 3, 11, 4, 6};
        take = 0; irq = 0; cause = '0; tval = '0; ack_idx = 0;
        for (int i = 0; i < 6; i++)
            if (exc[i] && !take) begin take = 1; cause = exc_cause[i]; end
        if (take) begin
            case (cause)
                2:       tval = inst_dec;
                0, 3:    tval = pc_dec;
                4, 6:    tval = mem_addr_exe;
                default: tval = '0;
            endcase
        end else begin
            for (int j = 0; j < int'(IRQW); j++) begin
                pos = (j == 0) ? 11 : (j == 1) ? 3 : (j == 2) ? 7 : 16 + j - 3;
                if (!take && csr_bus.mstatus_csr[3] && mip[pos] && mie[pos]) begin
                    take = 1; irq = 1; ack_idx = j;
                    cause = 32'h8000_0000 + pos;
                end
            end
        end
    endtask

    task automatic clear_events();
        ecall_dec = 0; ebreak_dec = 0; mret_dec = 0; illegal_inst_dec = 0;
        load_addr_mis_exe = 0; store_addr_mis_exe = 0;
        pc_dec = '0; inst_dec = '0; mem_addr_exe = '0;
        irq_ext = 0; irq_soft = 0; irq_timer = 0; irq_plat = '0;
    endtask

    task automatic rand_events();
        ecall_dec          = ($urandom_range(0, 11) == 0);
        ebreak_dec         = ($urandom_range(0, 11) == 0);
        illegal_inst_dec   = ($urandom_range(0, 11) == 0);
        load_addr_mis_exe  = ($urandom_range(0, 11) == 0);
        store_addr_mis_exe = ($urandom_range(0, 11) == 0);
        mret_dec           = ($urandom_range(0, 4) == 0);
        pc_dec             = $urandom;
        if ($urandom_range(0, 7) != 0) pc_dec[1:0] = 2'b00;
        inst_dec           = $urandom;
        mem_addr_exe       = $urandom;
        irq_ext            = ($urandom_range(0, 3) == 0);
        irq_soft           = ($urandom_range(0, 3) == 0);
        irq_timer          = ($urandom_range(0, 3) == 0);
        irq_plat           = N'($urandom & $urandom);
    endtask

    task automatic rand_csrs();
        csr_bus.mstatus_csr = $urandom;
        if ($urandom_range(0, 3) != 0) csr_bus.mstatus_csr[3] = 1'b1;
        csr_bus.mie_csr   = $urandom;
        csr_bus.mtvec_csr = $urandom;
        csr_bus.mepc_csr  = $urandom;
    endtask

    // Called #1 after a rising edge with the DUT idle and stimulus applied.
    task automatic run_txn();
        bit take, irq, mret;
        logic [31:0] cause, tval, ms, mtv, epc, mepc, exp_jump, st_trap, st_ret;
        logic [IRQW-1:0] ack_exp;
        int ack_idx;
        ref_trap(take, irq, cause, tval, ack_idx);
        ms   = csr_bus.mstatus_csr;
        mtv  = csr_bus.mtvec_csr;
        mepc = csr_bus.mepc_csr;
        epc  = pc_dec;
        mret = !take && mret_dec;
        exp_jump = {mtv[31:2], 2'b00};
        if (irq && mtv[1:0] == 2'b01) exp_jump = exp_jump + 32'(4 * (cause % 32));
        ack_exp = '0;
        if (irq) ack_exp[ack_idx] = 1'b1;
        st_trap = (ms & ~32'h0000_1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
        st_ret  = (ms & ~32'h0000_1888) | (ms[7] ? 32'h08 : 32'h0) | 32'h1880;
        for (int k = 0; k < 5; k++) obs_w[k] = '0;
        obs_jump = '0; obs_ack = '0;
        #1;
        chk("mip", mip_out, ref_mip());
        chk("flush_accept", 32'(pipe_flush), 32'(take || mret_dec));
        chk("busy_idle", 32'(busy), 32'd0);
        chk("wen_idle", 32'(csr_bus.csr_wen), 32'd0);
        if (take) begin
            for (int k = 1; k <= 5; k++) begin
                @(posedge clk); #1;
                chk("busy_trap", 32'(busy), 32'd1);
                chk("flush_trap", 32'(pipe_flush), 32'd1);
                chk("wen_trap", 32'(csr_bus.csr_wen), 32'(k <= 4));
                chk("jv_trap", 32'(jump_valid), 32'(k == 5));
                chk("ack_trap", 32'(irq_ack), (k == 5) ? 32'(ack_exp) : 32'd0);
                if (k <= 4) obs_w[k] = csr_bus.csr_wdata;
                case (k)
                    1: begin chk("addr_epc", 32'(csr_bus.csr_waddr), 32'h341); chk("mepc", csr_bus.csr_wdata, epc); end
                    2: begin chk("addr_status", 32'(csr_bus.csr_waddr), 32'h300); chk("mstatus", csr_bus.csr_wdata, st_trap); end
                    3: begin chk("addr_cause", 32'(csr_bus.csr_waddr), 32'h342); chk("mcause", csr_bus.csr_wdata, cause); end
                    4: begin chk("addr_tval", 32'(csr_bus.csr_waddr), 32'h343); chk("mtval", csr_bus.csr_wdata, tval); end
                    default: begin chk("jump_addr", jump_addr, exp_jump); obs_jump = jump_addr; obs_ack = irq_ack; end
                endcase
                rand_events();
            end
        end else if (mret) begin
            @(posedge clk); #1;
            chk("busy_rst", 32'(busy), 32'd1);
            chk("flush_rst", 32'(pipe_flush), 32'd1);
            chk("wen_rst", 32'(csr_bus.csr_wen), 32'd1);
            chk("addr_rst", 32'(csr_bus.csr_waddr), 32'h300);
            chk("mret_status", csr_bus.csr_wdata, st_ret);
            chk("jv_rst", 32'(jump_valid), 32'd0);
            obs_w[2] = csr_bus.csr_wdata;
            rand_events();
            @(posedge clk); #1;
            chk("busy_rjump", 32'(busy), 32'd1);
            chk("flush_rjump", 32'(pipe_flush), 32'd1);
            chk("wen_rjump", 32'(csr_bus.csr_wen), 32'd0);
            chk("jv_rjump", 32'(jump_valid), 32'd1);
            chk("rjump_addr", jump_addr, mepc);
            chk("ack_rjump", 32'(irq_ack), 32'd0);
            obs_jump = jump_addr;
            rand_events();
        end
        @(posedge clk); #1;
        chk("busy_done", 32'(busy), 32'd0);
        chk("wen_done", 32'(csr_bus.csr_wen), 32'd0);
        chk("jv_done", 32'(jump_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0;
        clear_events();
        csr_bus.mstatus_csr = '0; csr_bus.mie_csr = '0;
        csr_bus.mtvec_csr = '0; csr_bus.mepc_csr = '0;
        irq_ext = 1; irq_plat = 4'b1001; ecall_dec = 1;
        #2;
        chk("rst_mip", mip_out, 32'h0009_0800);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wen", 32'(csr_bus.csr_wen), 32'd0);
        chk("rst_flush", 32'(pipe_flush), 32'd0);
        chk("rst_jv", 32'(jump_valid), 32'd0);
        chk("rst_jaddr", jump_addr, 32'd0);
        chk("rst_ack", 32'(irq_ack), 32'd0);
        repeat (2) @(posedge clk);
        #1; rst_b = 1'b1; clear_events();

        // illegal instruction
        csr_bus.mstatus_csr = 32'h8; csr_bus.mtvec_csr = 32'h80;
        illegal_inst_dec = 1; pc_dec = 32'h100; inst_dec = 32'hFFFF_FFFF;
        run_txn();
        chk("ill_mepc", obs_w[1], 32'h100);
        chk("ill_status", obs_w[2], 32'h1880);
        chk("ill_cause", obs_w[3], 32'd2);
        chk("ill_tval", obs_w[4], 32'hFFFF_FFFF);
        chk("ill_jump", obs_jump, 32'h80);

        // vectored timer
        clear_events();
        csr_bus.mtvec_csr = 32'h201; csr_bus.mie_csr = 32'h80; irq_timer = 1; pc_dec = 32'h400;
        run_txn();
        chk("tmr_cause", obs_w[3], 32'h8000_0007);
        chk("tmr_tval", obs_w[4], 32'd0);
        chk("tmr_jump", obs_jump, 32'h21C);

        // platform line 2
        clear_events();
        csr_bus.mtvec_csr = 32'h80; csr_bus.mie_csr = 32'h0004_0000; irq_plat = 4'b0100;
        run_txn();
        chk("plat_cause", obs_w[3], 32'h8000_0012);
        chk("plat_ack", 32'(obs_ack), 32'h20);

        // ecall + ext + mret together
        clear_events();
        csr_bus.mie_csr = 32'h800; csr_bus.mepc_csr = 32'h444;
        ecall_dec = 1; irq_ext = 1; mret_dec = 1; pc_dec = 32'h500;
        run_txn();
        chk("sim_cause", obs_w[3], 32'd11);
        chk("sim_ack", 32'(obs_ack), 32'd0);
        chk("sim_jump", obs_jump, 32'h80);

        // mret
        clear_events();
        csr_bus.mstatus_csr = 32'h1880; csr_bus.mepc_csr = 32'h104; mret_dec = 1;
        run_txn();
        chk("mret_status", obs_w[2], 32'h1888);
        chk("mret_jump", obs_jump, 32'h104);

        // reset while in CAUSE
        clear_events();
        csr_bus.mstatus_csr = 32'h8;
        illegal_inst_dec = 1; pc_dec = 32'h200; inst_dec = 32'h1234_5678;
        repeat (3) begin
            @(posedge clk); #1; clear_events();
        end
        chk("mid_addr_cause", 32'(csr_bus.csr_waddr), 32'h342);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_wen", 32'(csr_bus.csr_wen), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_jv", 32'(jump_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1; rst_b = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("post_rst_wen", 32'(csr_bus.csr_wen), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        for (int t = 0; t < 300; t++) begin
            rand_csrs();
            rand_events();
            run_txn();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
